// File: rtl/trace_pkg.sv
// Shared constants for the trace command receiver: framing bytes, command codes,
// FSM state encoding and the per-command payload length.
package trace_pkg;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  localparam logic [7:0] CMD_SET_DELAY = 8'h01;
  localparam logic [7:0] CMD_SET_KEY   = 8'h02;
  localparam logic [7:0] CMD_SET_PT    = 8'h03;
  localparam logic [7:0] CMD_RUN       = 8'h04;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CHK     = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;

  function automatic logic cmd_known(input logic [7:0] cmd);
    return (cmd == CMD_SET_DELAY) || (cmd == CMD_SET_KEY) ||
           (cmd == CMD_SET_PT) || (cmd == CMD_RUN);
  endfunction

  // Unknown codes report 0; callers gate on cmd_known first.
  function automatic logic [15:0] payload_len(input logic [7:0]  cmd,
                                              input logic [15:0] key_bytes,
                                              input logic [15:0] pt_bytes);
    case (cmd)
      CMD_SET_DELAY: return 16'd1;
      CMD_SET_KEY:   return key_bytes;
      CMD_SET_PT:    return pt_bytes;
      default:       return 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/rx_timeout.sv
// Inter-byte idle counter: cleared by load_i, advances while en_i, and flags
// expiry combinationally once LIMIT-1 idle cycles have been counted.
module rx_timeout #(
  parameter int unsigned LIMIT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired_o = en_i && (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/trace_cmd_rx.sv
// UART command framer for the trace capture rig: parses SYNC/CMD/payload/CHK
// frames, commits key/plaintext/delay on a good checksum and answers ACK/NAK.
module trace_cmd_rx
  import trace_pkg::*;
#(
  parameter int unsigned KEY_SIZE       = 80,
  parameter int unsigned BLOCK_SIZE     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_dv,
  input  logic [7:0]            rx_byte,
  input  logic                  busy,
  output logic [KEY_SIZE-1:0]   key_o,
  output logic [BLOCK_SIZE-1:0] pt_o,
  output logic [7:0]            delay_o,
  output logic                  start_o,
  output logic                  ack_valid,
  output logic [7:0]            ack_byte,
  input  logic                  ack_ready,
  output logic [2:0]            err_o,
  output logic [2:0]            state_o
);

  localparam int unsigned SH_W      = (KEY_SIZE > BLOCK_SIZE) ? KEY_SIZE : BLOCK_SIZE;
  localparam logic [15:0] KEY_BYTES = 16'(KEY_SIZE / 8);
  localparam logic [15:0] PT_BYTES  = 16'(BLOCK_SIZE / 8);

  logic [2:0]            state_q, state_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [7:0]            chk_q, chk_d;
  logic [15:0]           rem_q, rem_d;
  logic [SH_W-1:0]       shadow_q, shadow_d;
  logic [KEY_SIZE-1:0]   key_q, key_d;
  logic [BLOCK_SIZE-1:0] pt_q, pt_d;
  logic [7:0]            delay_q, delay_d;
  logic                  start_q, start_d;
  logic [7:0]            ack_byte_q, ack_byte_d;
  logic [2:0]            err_q, err_d;

  logic        in_frame;
  logic        expired;
  logic        timeout_hit;
  logic [15:0] len_w;

  // ack_valid/ready: the response byte is offered while in RESP and retires on
  // the first edge where ack_ready is high; ack_byte never changes while offered.
  assign in_frame    = (state_q == ST_CMD) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
  assign timeout_hit = expired && !rx_dv;
  assign len_w       = payload_len(rx_byte, KEY_BYTES, PT_BYTES);

  rx_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_rx_timeout (
    .clk      (clk),
    .rst      (rst),
    .load_i   (rx_dv || !in_frame),
    .en_i     (in_frame),
    .expired_o(expired)
  );

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    chk_d      = chk_q;
    rem_d      = rem_q;
    shadow_d   = shadow_q;
    key_d      = key_q;
    pt_d       = pt_q;
    delay_d    = delay_q;
    start_d    = 1'b0;
    ack_byte_d = ack_byte_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_dv && (rx_byte == SYNC)) begin
          state_d  = ST_CMD;
          shadow_d = '0;
          chk_d    = '0;
        end
      end
      ST_CMD: begin
        if (rx_dv) begin
          if (cmd_known(rx_byte)) begin
            cmd_d   = rx_byte;
            chk_d   = rx_byte;
            rem_d   = len_w;
            state_d = (len_w == 16'd0) ? ST_CHK : ST_PAYLOAD;
          end else begin
            err_d[1]   = 1'b1;
            ack_byte_d = NAK;
            state_d    = ST_RESP;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_dv) begin
          shadow_d = {shadow_q[SH_W-9:0], rx_byte};
          chk_d    = chk_q ^ rx_byte;
          rem_d    = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (rx_dv) begin
          state_d = ST_RESP;
          if (rx_byte == chk_q) begin
            ack_byte_d = ACK;
            case (cmd_q)
              CMD_SET_DELAY: delay_d = shadow_q[7:0];
              CMD_SET_KEY:   key_d   = shadow_q[KEY_SIZE-1:0];
              CMD_SET_PT:    pt_d    = shadow_q[BLOCK_SIZE-1:0];
              CMD_RUN: begin
                if (busy) ack_byte_d = NAK;
                else      start_d    = 1'b1;
              end
              default: ack_byte_d = NAK;
            endcase
          end else begin
            err_d[0]   = 1'b1;
            ack_byte_d = NAK;
          end
        end
      end
      ST_RESP: begin
        if (ack_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A byte in the expiry cycle keeps the frame alive; otherwise drop it silently.
    if (timeout_hit) begin
      err_d[2] = 1'b1;
      state_d  = ST_IDLE;
      shadow_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      chk_q      <= '0;
      rem_q      <= '0;
      shadow_q   <= '0;
      key_q      <= '0;
      pt_q       <= '0;
      delay_q    <= 8'h0F;
      start_q    <= 1'b0;
      ack_byte_q <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      chk_q      <= chk_d;
      rem_q      <= rem_d;
      shadow_q   <= shadow_d;
      key_q      <= key_d;
      pt_q       <= pt_d;
      delay_q    <= delay_d;
      start_q    <= start_d;
      ack_byte_q <= ack_byte_d;
      err_q      <= err_d;
    end
  end

  assign key_o     = key_q;
  assign pt_o      = pt_q;
  assign delay_o   = delay_q;
  assign start_o   = start_q;
  assign ack_valid = (state_q == ST_RESP);
  assign ack_byte  = ack_byte_q;
  assign err_o     = err_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_trace_cmd_rx.sv
// Directed bench for trace_cmd_rx: stimulus pushes expected response bytes,
// a negedge monitor pops and checks them whenever ack_valid is presented.
module tb_trace_cmd_rx;
  import trace_pkg::*;

  localparam int unsigned TO = 64;

  logic        clk;
  logic        rst;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        busy;
  logic [79:0] key_o;
  logic [63:0] pt_o;
  logic [7:0]  delay_o;
  logic        start_o;
  logic        ack_valid;
  logic [7:0]  ack_byte;
  logic        ack_ready;
  logic [2:0]  err_o;
  logic [2:0]  state_o;

  int tests = 0;
  int fails = 0;
  int ack_cnt = 0;
  int start_cnt = 0;
  int ack_snap;
  logic [7:0] exp_q[$];

  trace_cmd_rx #(.KEY_SIZE(80), .BLOCK_SIZE(64), .TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_dv    (rx_dv),
    .rx_byte  (rx_byte),
    .busy     (busy),
    .key_o    (key_o),
    .pt_o     (pt_o),
    .delay_o  (delay_o),
    .start_o  (start_o),
    .ack_valid(ack_valid),
    .ack_byte (ack_byte),
    .ack_ready(ack_ready),
    .err_o    (err_o),
    .state_o  (state_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    tick(1);
    rx_dv   = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_key"},   key_o, '0);
    check({tag, "_pt"},    pt_o, '0);
    check({tag, "_delay"}, delay_o, 8'h0F);
    check({tag, "_start"}, start_o, 1'b0);
    check({tag, "_avld"},  ack_valid, 1'b0);
    check({tag, "_abyte"}, ack_byte, 8'h00);
    check({tag, "_err"},   err_o, 3'b000);
    check({tag, "_state"}, state_o, ST_IDLE);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (start_o) start_cnt++;
      if (ack_valid) begin
        if (exp_q.size() == 0) begin
          check("ack_unexpected", ack_valid, 1'b0);
        end else begin
          check("ack_byte", ack_byte, exp_q[0]);
          if (ack_ready) begin
            void'(exp_q.pop_front());
            ack_cnt++;
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; busy = 1'b0; ack_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    check_reset_values("reset");

    // SET_DELAY with the response held off for a few cycles
    ack_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h20);
    check("delay_before_chk", delay_o, 8'h0F);
    exp_q.push_back(8'h06);
    send_byte(8'h21);
    check("delay_set", delay_o, 8'h20);
    check("ack_latency", ack_valid, 1'b1);
    tick(5);
    check("ack_held", ack_valid, 1'b1);
    ack_ready = 1'b1;
    tick(2);
    check("ack_cnt_delay", ack_cnt, 1);
    check("idle_after_ack", state_o, ST_IDLE);

    // SET_KEY good, then bad checksums
    exp_q.push_back(8'h06);
    send_byte(8'hA5); send_byte(8'h02);
    for (int i = 0; i < 10; i++) send_byte(8'(i));
    send_byte(8'h03);
    check("key_set", key_o, 80'h00010203040506070809);
    tick(2);
    exp_q.push_back(8'h15);
    send_byte(8'hA5); send_byte(8'h02);
    for (int i = 0; i < 10; i++) send_byte(8'(i));
    send_byte(8'h02);
    check("key_badchk", key_o, 80'h00010203040506070809);
    check("err_chk", err_o[0], 1'b1);
    tick(2);
    exp_q.push_back(8'h15);
    send_byte(8'hA5); send_byte(8'h02);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h10 + i));
    send_byte(8'h83);
    check("key_badchk2", key_o, 80'h00010203040506070809);
    tick(2);

    // RUN idle and busy
    busy = 1'b0;
    exp_q.push_back(8'h06);
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h04);
    check("start_pulse", start_o, 1'b1);
    tick(1);
    check("start_one_cycle", start_o, 1'b0);
    check("start_cnt1", start_cnt, 1);
    tick(1);
    busy = 1'b1;
    exp_q.push_back(8'h15);
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h04);
    check("start_busy", start_o, 1'b0);
    tick(2);
    check("start_cnt_busy", start_cnt, 1);
    busy = 1'b0;

    // Byte landing in the expiry cycle keeps the frame alive
    exp_q.push_back(8'h06);
    send_byte(8'hA5); send_byte(8'h01);
    tick(TO - 1);
    send_byte(8'h33); send_byte(8'h32);
    check("delay_boundary", delay_o, 8'h33);
    check("no_timeout_boundary", err_o[2], 1'b0);
    tick(2);

    // Timeout inside SET_PT
    ack_snap = ack_cnt;
    send_byte(8'hA5); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    tick(TO + 5);
    check("err_timeout", err_o[2], 1'b1);
    check("pt_after_timeout", pt_o, 64'h0);
    check("state_after_timeout", state_o, ST_IDLE);
    check("no_ack_timeout", ack_cnt, ack_snap);
    exp_q.push_back(8'h06);
    send_byte(8'hA5); send_byte(8'h03);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    send_byte(8'h0B);
    check("pt_set", pt_o, 64'h0102030405060708);
    tick(2);

    // Unknown command, response stalled while a frame arrives
    ack_ready = 1'b0;
    exp_q.push_back(8'h15);
    send_byte(8'hA5); send_byte(8'h7E);
    check("err_unknown", err_o[1], 1'b1);
    check("nak_unknown_valid", ack_valid, 1'b1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h44); send_byte(8'h45);
    tick(46);
    check("delay_dropped", delay_o, 8'h33);
    ack_ready = 1'b1;
    tick(2);
    check("idle_after_unknown", state_o, ST_IDLE);
    check("ack_cnt_total", ack_cnt, 9);

    // Reset in the middle of SET_PT
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'hAA); send_byte(8'hBB);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_reset_values("midrst");
    exp_q.push_back(8'h06);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h55); send_byte(8'h54);
    check("delay_after_rst", delay_o, 8'h55);
    tick(3);

    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trace_cmd_rx.md
TRACE_CMD_RX -- requirements
Module: trace_cmd_rx

Interface
REQ-001 SHALL have parameter KEY_SIZE, default 80, meaning key width in bits (multiple of 8).
REQ-002 SHALL have parameter BLOCK_SIZE, default 64, meaning plaintext width in bits (multiple of 8).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the maximum number of idle clk cycles allowed between bytes inside one frame.
REQ-004 SHALL have port clk, input, 1, the single clock; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port rx_dv, input, 1, one-cycle strobe from the UART receiver meaning rx_byte is valid.
REQ-007 SHALL have port rx_byte, input, 8, the received byte.
REQ-008 SHALL have port busy, input, 1, meaning the capture engine is busy and a RUN command is refused.
REQ-009 SHALL have port key_o, output, KEY_SIZE, the committed cipher key.
REQ-010 SHALL have port pt_o, output, BLOCK_SIZE, the committed plaintext.
REQ-011 SHALL have port delay_o, output, 8, the committed sensor delay value.
REQ-012 SHALL have port start_o, output, 1, a one-cycle pulse requesting one encryption plus trace capture.
REQ-013 SHALL have ports ack_valid (output, 1), ack_byte (output, 8) and ack_ready (input, 1), the response handshake toward the UART transmitter.
REQ-014 SHALL have port err_o, output, 3, sticky flags: [0] checksum, [1] unknown command, [2] timeout; cleared only by rst.

Function
REQ-015 SHALL accept frames of the form SYNC 0xA5, CMD, payload, CHK, where CHK is the XOR of CMD and all payload bytes.
REQ-016 SHALL use these commands: 0x01 SET_DELAY (1 payload byte); 0x02 SET_KEY (KEY_SIZE/8 bytes, MSB first); 0x03 SET_PT (BLOCK_SIZE/8 bytes, MSB first); 0x04 RUN (0 bytes).
REQ-017 SHALL implement the FSM IDLE -> CMD -> PAYLOAD -> CHK -> RESP -> IDLE; PAYLOAD is skipped when the payload length is 0.
REQ-018 In IDLE, SHALL discard any byte other than 0xA5 without raising an error.
REQ-019 In CMD, an unknown code SHALL set err_o[1], skip directly to RESP with NAK 0x15, and consume no further bytes for that frame.
REQ-020 SHALL shift payload bytes into a shadow register; key_o, pt_o and delay_o SHALL update only in the cycle after a matching CHK.
REQ-021 A CHK mismatch SHALL set err_o[0], leave all outputs unchanged, and respond NAK 0x15.
REQ-022 A good RUN SHALL pulse start_o for exactly 1 cycle, in the cycle after CHK, and respond ACK 0x06, only if busy=0; if busy=1 it SHALL respond NAK 0x15 with no pulse.
REQ-023 Any other good frame SHALL respond ACK 0x06.
REQ-024 In RESP, SHALL hold ack_valid=1 and ack_byte stable until a cycle with ack_ready=1, then return to IDLE on the next edge.
REQ-025 Bytes arriving while in RESP SHALL be dropped.
REQ-026 SHALL reset the timeout counter on every rx_dv and count only in CMD, PAYLOAD and CHK.
REQ-027 When the timeout counter reaches TIMEOUT_CYCLES-1, SHALL set err_o[2], discard the shadow register, return to IDLE, and send no response.
REQ-028 If rx_dv and timeout expiry occur in the same cycle, the byte SHALL win and no timeout SHALL occur.
REQ-029 Latency from the CHK byte strobe to ack_valid=1 SHALL be 1 cycle.

Reset
REQ-030 On rst, SHALL enter IDLE with key_o=0, pt_o=0, delay_o=15, start_o=0, ack_valid=0, ack_byte=0, err_o=0, and the shadow register and counters cleared.
REQ-031 rst asserted mid-frame or in RESP SHALL abort without a response, and without a start_o pulse, in the same edge.

Structure
REQ-032 SHALL place SYNC, ACK, NAK, the command codes, the payload-length function and the FSM state encoding in a shared package trace_pkg.
REQ-033 SHALL instantiate a single sub-module rx_timeout (load/enable counter with an expiry flag); all other logic stays in trace_cmd_rx.

Verification
REQ-034 Feed A5 01 20 21 -> delay_o=0x20 one cycle after CHK; ack_byte=0x06 held until ack_ready.
REQ-035 Feed A5 02, ten key bytes 00..09, XOR-correct CHK -> key_o=80'h00010203040506070809; then repeat with the CHK bit-flipped -> key_o unchanged, err_o[0]=1, NAK.
REQ-036 Feed A5 04 04 with busy=0 -> single start_o pulse plus ACK; with busy=1 -> no pulse, NAK 0x15.
REQ-037 Feed A5 03, three bytes, then stall for TIMEOUT_CYCLES -> err_o[2]=1, pt_o unchanged, no ack_valid; a following good frame is accepted normally.
REQ-038 Feed A5 7E -> err_o[1]=1, NAK; hold ack_ready=0 for 50 cycles while bytes arrive -> ack_byte stable and the bytes are dropped; assert rst mid-SET_PT -> outputs return to their reset values.
